req_encoder_4x2: RTL and testbench



---
 rtl/req_encoder_4x2.sv | 85 ++++++++
 tb/tb_req_encoder_4x2.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/req_encoder_4x2.sv
// Sequential 4-to-2 request encoder: sticky request capture with a valid/ready grant output.
// Round-robin arbitration by default; define FIXED_PRIO_EN for lowest-index-wins priority.
module req_encoder_4x2 #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  input  logic             ready,
  output logic [N_REQ-1:0] pending,
  output logic             dup
);

  logic             slot_free;
  logic             found;
  logic             grant;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] cand;
  logic [N_REQ-1:0] grant_clear;
  logic [N_REQ-1:0] req_cap;
  logic [N_REQ-1:0] pending_next;
  logic             dup_next;

`ifndef FIXED_PRIO_EN
  logic [IDX_W-1:0] ptr;
`endif

  assign slot_free = !valid || ready;

  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
`ifdef FIXED_PRIO_EN
      cand = IDX_W'(i);
`else
      // Index arithmetic wraps naturally because N_REQ == 2**IDX_W.
      cand = ptr + IDX_W'(i);
`endif
      if (!found && pending[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    grant        = slot_free && found;
    grant_clear  = grant ? (N_REQ'(1) << sel) : '0;
    req_cap      = en ? req : '0;
    // A bit granted and re-requested at the same edge stays pending and is not a dup.
    pending_next = (pending & ~grant_clear) | req_cap;
    dup_next     = |(req_cap & pending & ~grant_clear);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      idx     <= '0;
      valid   <= 1'b0;
      dup     <= 1'b0;
`ifndef FIXED_PRIO_EN
      ptr     <= '0;
`endif
    end else begin
      pending <= pending_next;
      dup     <= dup_next;
      if (grant) begin
        idx   <= sel;
        valid <= 1'b1;
`ifndef FIXED_PRIO_EN
        ptr   <= sel + 1'b1;
`endif
      end else if (slot_free) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_req_encoder_4x2.sv
// Directed self-checking bench for req_encoder_4x2; inputs driven and outputs sampled at negedge.
module tb_req_encoder_4x2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [1:0] idx;
  logic       valid;
  logic       ready;
  logic [3:0] pending;
  logic       dup;

  int checks = 0;
  int errors = 0;

  req_encoder_4x2 #(.N_REQ(4), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .idx(idx),
    .valid(valid), .ready(ready), .pending(pending), .dup(dup)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; req = 4'b0000; ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req = 4'b1111; ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (valid !== 1'b0 || pending !== 4'b0000 || dup !== 1'b0 || idx !== 2'd0) begin
        errors++;
        $display("FAIL reset cyc%0d: valid=%b pending=%b dup=%b idx=%0d, want 0 0000 0 0",
                 c, valid, pending, dup, idx);
      end
    end
    rst = 1'b0; req = 4'b0000;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100; ready = 1'b1;
    tick();
    req = 4'b0000;
    checks++;
    if (pending !== 4'b0100 || valid !== 1'b0) begin
      errors++;
      $display("FAIL single_capture: pending=%b valid=%b, want 0100 0", pending, valid);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || idx !== 2'd2 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL single_grant: valid=%b idx=%0d pending=%b, want 1 2 0000", valid, idx, pending);
    end
    tick();
    checks++;
    if (valid !== 1'b0 || idx !== 2'd2) begin
      errors++;
      $display("FAIL single_drain: valid=%b idx=%0d, want 0 2 (idx held)", valid, idx);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      req = 4'b1111; ready = 1'b1;
      tick();
      req = 4'b0000;
      checks++;
      if (pending !== 4'b1111 || valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_capture r%0d: pending=%b valid=%b, want 1111 0", r, pending, valid);
      end
      for (int k = 0; k < 4; k++) begin
        tick();
        checks++;
        if (valid !== 1'b1 || idx !== 2'(k)) begin
          errors++;
          $display("FAIL b2b_seq r%0d k%0d: valid=%b idx=%0d, want 1 %0d", r, k, valid, idx, k);
        end
      end
      tick();
      checks++;
      if (valid !== 1'b0 || pending !== 4'b0000) begin
        errors++;
        $display("FAIL b2b_end r%0d: valid=%b pending=%b, want 0 0000", r, valid, pending);
      end
    end
  endtask

  task automatic test_rr_vs_fixed();
    logic [1:0] exp_idx;
`ifdef FIXED_PRIO_EN
    exp_idx = 2'd0;
`else
    exp_idx = 2'd3;
`endif
    do_reset();
    ready = 1'b0; req = 4'b1001;
    tick();
    req = 4'b0000;
    tick();
    checks++;
    if (valid !== 1'b1 || idx !== 2'd0 || pending !== 4'b1000) begin
      errors++;
      $display("FAIL prio_first: valid=%b idx=%0d pending=%b, want 1 0 1000", valid, idx, pending);
    end
    req = 4'b0001;
    tick();
    req = 4'b0000; ready = 1'b1;
    checks++;
    if (pending !== 4'b1001) begin
      errors++;
      $display("FAIL prio_refill: pending=%b, want 1001", pending);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || idx !== exp_idx) begin
      errors++;
      $display("FAIL prio_second: valid=%b idx=%0d, want 1 %0d", valid, idx, exp_idx);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready = 1'b0; req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    checks++;
    if (valid !== 1'b1 || idx !== 2'd1) begin
      errors++;
      $display("FAIL bp_grant: valid=%b idx=%0d, want 1 1", valid, idx);
    end
    for (int c = 0; c < 5; c++) begin
      req = (c == 0) ? 4'b1000 : 4'b0000;
      tick();
      checks++;
      if (valid !== 1'b1 || idx !== 2'd1 || pending !== 4'b1000) begin
        errors++;
        $display("FAIL bp_hold c%0d: valid=%b idx=%0d pending=%b, want 1 1 1000",
                 c, valid, idx, pending);
      end
    end
    req = 4'b0000; ready = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b1 || idx !== 2'd3 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL bp_release: valid=%b idx=%0d pending=%b, want 1 3 0000", valid, idx, pending);
    end
  endtask

  task automatic test_dup();
    do_reset();
    ready = 1'b0; req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0010;
    tick();
    checks++;
    if (dup !== 1'b0 || pending !== 4'b0010 || valid !== 1'b1) begin
      errors++;
      $display("FAIL dup_first: dup=%b pending=%b valid=%b, want 0 0010 1", dup, pending, valid);
    end
    tick();
    checks++;
    if (dup !== 1'b1 || pending !== 4'b0010) begin
      errors++;
      $display("FAIL dup_second: dup=%b pending=%b, want 1 0010", dup, pending);
    end
    en = 1'b0; req = 4'b0110;
    tick();
    checks++;
    if (dup !== 1'b0 || pending !== 4'b0010) begin
      errors++;
      $display("FAIL dup_en_off: dup=%b pending=%b, want 0 0010", dup, pending);
    end
    // grant of bit 1 coincides with a re-request of bit 1
    en = 1'b1; req = 4'b0010; ready = 1'b1;
    tick();
    req = 4'b0000;
    checks++;
    if (valid !== 1'b1 || idx !== 2'd1 || pending !== 4'b0010 || dup !== 1'b0) begin
      errors++;
      $display("FAIL dup_set_wins: valid=%b idx=%0d pending=%b dup=%b, want 1 1 0010 0",
               valid, idx, pending, dup);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready = 1'b0; req = 4'b0111;
    tick();
    req = 4'b0000;
    tick();
    checks++;
    if (valid !== 1'b1 || idx !== 2'd0 || pending !== 4'b0110) begin
      errors++;
      $display("FAIL mid_setup: valid=%b idx=%0d pending=%b, want 1 0 0110", valid, idx, pending);
    end
    rst = 1'b1; req = 4'b1111;
    tick();
    checks++;
    if (valid !== 1'b0 || pending !== 4'b0000 || dup !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b pending=%b dup=%b, want 0 0000 0", valid, pending, dup);
    end
    rst = 1'b0; req = 4'b1001; ready = 1'b1;
    tick();
    req = 4'b0000;
    tick();
    checks++;
    if (valid !== 1'b1 || idx !== 2'd0) begin
      errors++;
      $display("FAIL mid_ptr_reset: valid=%b idx=%0d, want 1 0", valid, idx);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0000; ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_rr_vs_fixed();
    test_backpressure();
    test_dup();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
